// File: rtl/debug_inst_scratch_loader.sv
// Byte-stream loader for the debug instruction RAM scratch port.
// Decodes WRITE/READ bursts and walks a linear {row,lane} byte pointer.
module debug_inst_scratch_loader #(
    parameter int ROW_BITS  = 8,
    parameter int LANE_BITS = 3,
    localparam int ADDR_BITS = ROW_BITS + LANE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid_i,
    input  logic [7:0]           cmd_data_i,
    output logic                 cmd_ready_o,
    output logic                 rsp_valid_o,
    output logic [7:0]           rsp_data_o,
    input  logic                 rsp_ready_i,
    output logic [ADDR_BITS-1:0] instScratchAddr_o,
    output logic [7:0]           instScratchWrData_o,
    output logic                 instScratchWrEn_o,
    input  logic [7:0]           instScratchRdData_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 bad_cmd_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_LEN_LO,
        S_LEN_HI,
        S_WRITE,
        S_READ
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    state_t               state;
    logic [ADDR_BITS-1:0] ptr;
    logic [15:0]          cnt;
    logic                 is_read;
    logic                 last_loaded;
    logic                 hs;

    assign cmd_ready_o = !reset && (state != S_READ);
    assign hs          = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state != S_IDLE);

    // Linear pointer is {row,lane}; the RAM wants {lane,row}.
    assign instScratchAddr_o =
        {ptr[LANE_BITS-1:0], ptr[ADDR_BITS-1:LANE_BITS]};

    assign instScratchWrEn_o   = (state == S_WRITE) && hs;
    assign instScratchWrData_o = instScratchWrEn_o ? cmd_data_i : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            is_read     <= 1'b0;
            last_loaded <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 8'h00;
            done_o      <= 1'b0;
            bad_cmd_o   <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            bad_cmd_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hs) begin
                        if (cmd_data_i == OP_WRITE || cmd_data_i == OP_READ) begin
                            is_read <= (cmd_data_i == OP_READ);
                            state   <= S_ADDR_LO;
                        end else begin
                            bad_cmd_o <= 1'b1;
                        end
                    end
                end
                S_ADDR_LO: begin
                    if (hs) begin
                        ptr   <= ADDR_BITS'(cmd_data_i);
                        state <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (hs) begin
                        ptr   <= ADDR_BITS'({cmd_data_i, 8'(ptr)});
                        state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (hs) begin
                        cnt[7:0] <= cmd_data_i;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (hs) begin
                        cnt[15:8]   <= cmd_data_i;
                        last_loaded <= 1'b0;
                        state       <= is_read ? S_READ : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (hs) begin
                        ptr <= ptr + 1'b1;
                        if (cnt == 16'd0) begin
                            done_o <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // Leave only once the final loaded byte is taken.
                    if (rsp_valid_o && rsp_ready_i && last_loaded) begin
                        rsp_valid_o <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= S_IDLE;
                    end else if ((!rsp_valid_o || rsp_ready_i) && !last_loaded) begin
                        rsp_data_o  <= instScratchRdData_i;
                        rsp_valid_o <= 1'b1;
                        ptr         <= ptr + 1'b1;
                        if (cnt == 16'd0) begin
                            last_loaded <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
